// File: rtl/pipeline_hazard_pkg.sv
// Shared types and constants for the pipeline data-hazard controller.
// Shadow rd fields are stored at SHADOW_RD_W bits; REG_W must not exceed it.
package pipeline_hazard_pkg;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  localparam int SHADOW_RD_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [SHADOW_RD_W-1:0] rd;
    logic                   wreg;
    logic                   m2reg;
  } shadow_stage_t;

  localparam logic [SHADOW_RD_W-1:0] REG_ZERO = '0;

  // A stage can supply src only if it really writes a non-zero register equal to src.
  function automatic logic dest_match(input shadow_stage_t s,
                                      input logic [SHADOW_RD_W-1:0] src);
    return s.valid & s.wreg & (s.rd != REG_ZERO) & (s.rd == src);
  endfunction

endpackage

// File: rtl/hz_shadow_stage.sv
// One shadow pipeline slot: loads d_i each edge unless held; clr_valid_i
// inserts an empty slot instead.
module hz_shadow_stage
  import pipeline_hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_i,
  input  logic          clr_valid_i,
  input  shadow_stage_t d_i,
  output shadow_stage_t q_o
);

  shadow_stage_t stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (!hold_i) begin
      stage_d = d_i;
      if (clr_valid_i) stage_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Data-hazard controller beside ID: load-use stall, branch flush, operand
// forwarding selects from shadow EX/MEM destination info, plus perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_wait,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_branch_taken,
  output logic             wpcir,
  output logic             bubble,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  shadow_stage_t ex_q, mem_q, id_stage;
  logic [SHADOW_RD_W-1:0] rs_ext, rt_ext;
  logic loaduse;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  assign rs_ext = SHADOW_RD_W'(id_rs);
  assign rt_ext = SHADOW_RD_W'(id_rt);

  assign id_stage.valid = id_valid;
  assign id_stage.rd    = SHADOW_RD_W'(id_rd);
  assign id_stage.wreg  = id_wreg;
  assign id_stage.m2reg = id_m2reg;

  // Load in EX whose result a real ID instruction needs right now.
  assign loaduse = id_valid & ex_q.m2reg &
                   ((id_use_rs & dest_match(ex_q, rs_ext)) |
                    (id_use_rt & dest_match(ex_q, rt_ext)));

  assign wpcir      = ~mem_wait & ~loaduse;
  assign bubble     = ~mem_wait &  loaduse;
  assign flush_ifid = ~mem_wait & ~loaduse & id_valid & id_branch_taken;

  // EX loads never forward; such a source falls through to the MEM check.
  always_comb begin
    fwd_a = FWD_REG;
    if (dest_match(ex_q, rs_ext) && !ex_q.m2reg)
      fwd_a = FWD_EXALU;
    else if (dest_match(mem_q, rs_ext))
      fwd_a = mem_q.m2reg ? FWD_MEMLD : FWD_MEMALU;

    fwd_b = FWD_REG;
    if (dest_match(ex_q, rt_ext) && !ex_q.m2reg)
      fwd_b = FWD_EXALU;
    else if (dest_match(mem_q, rt_ext))
      fwd_b = mem_q.m2reg ? FWD_MEMLD : FWD_MEMALU;
  end

  hz_shadow_stage u_ex_stage (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (mem_wait),
    .clr_valid_i (~id_valid | loaduse),
    .d_i         (id_stage),
    .q_o         (ex_q)
  );

  hz_shadow_stage u_mem_stage (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (mem_wait),
    .clr_valid_i (1'b0),
    .d_i         (ex_q),
    .q_o         (mem_q)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!mem_wait) begin
      if (loaduse)    stall_count_d = stall_count_q + 1'b1;
      if (flush_ifid) flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
